// File: rtl/coin_disp_pkg.sv
// Shared definitions for the coin machine drive and debounce logic.
// State encoding and default timing constants.
package coin_disp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  localparam int DEF_ON_CYCLES  = 25000000;
  localparam int DEF_OFF_CYCLES = 25000000;
  localparam int DEF_CNT_W      = 26;
  localparam int DEF_COUNT_W    = 8;

endpackage

// File: rtl/phase_timer.sv
// Phase timer: counts up from a load to a terminal value, then holds.
// expired flags count==terminal.
module phase_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] terminal,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  assign expired = (count == terminal);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/coin_dispense_driver.sv
// Coin dispense driver: turns a request for N coins into N timed
// actuator pulses, then reports completion (normal or aborted).
module coin_dispense_driver
  import coin_disp_pkg::*;
#(
  parameter int ON_CYCLES  = DEF_ON_CYCLES,
  parameter int OFF_CYCLES = DEF_OFF_CYCLES,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int COUNT_W    = DEF_COUNT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [COUNT_W-1:0] req_count,
  output logic               req_ready,
  input  logic               abort,
  output logic               actuator,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [COUNT_W-1:0] dispensed
);

  localparam logic [CNT_W-1:0] ON_T  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_T = CNT_W'(OFF_CYCLES - 1);

  state_t             state, state_n;
  logic [COUNT_W-1:0] remaining, remaining_n;
  logic [COUNT_W-1:0] dispensed_n;
  logic               done_n, aborted_n;
  logic               load, expired;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .terminal ((state == S_ON) ? ON_T : OFF_T),
    .expired  (expired)
  );

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    dispensed_n = dispensed;
    done_n      = 1'b0;
    aborted_n   = 1'b0;
    load        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          dispensed_n = '0;
          if (req_count == '0) begin
            done_n = 1'b1;
          end else begin
            remaining_n = req_count;
            load        = 1'b1;
            state_n     = S_ON;
          end
        end
      end
      S_ON: begin
        // abort beats a coincident terminal count: pulse not counted
        if (abort) begin
          state_n   = S_IDLE;
          done_n    = 1'b1;
          aborted_n = 1'b1;
        end else if (expired) begin
          dispensed_n = dispensed + 1'b1;
          remaining_n = remaining - 1'b1;
          load        = 1'b1;
          state_n     = S_OFF;
        end
      end
      S_OFF: begin
        if (abort) begin
          state_n   = S_IDLE;
          done_n    = 1'b1;
          aborted_n = 1'b1;
        end else if (expired) begin
          if (remaining == '0) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else begin
            load    = 1'b1;
            state_n = S_ON;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      dispensed <= '0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      actuator  <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      dispensed <= dispensed_n;
      done      <= done_n;
      aborted   <= aborted_n;
      actuator  <= (state_n == S_ON);
    end
  end

endmodule
